// File: rtl/sym_pkg.sv
// ============================================================================
//  Module   : sym_pkg
//  Brief    : Shared types and constants for the answer stage.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package sym_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        RESULT = 2'd2
    } ans_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is always off
    localparam logic [7:0] SEG_DIGITS [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

endpackage

`default_nettype wire

// File: rtl/answer_checker_if.sv
// ============================================================================
//  Module   : answer_checker_if
//  Brief    : Game-side pulses in, guess/result/score/display out.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface answer_checker_if;
    logic       answerSig;
    logic [7:0] numSpecial;
    logic       btnUp;
    logic       btnDown;
    logic       btnEnter;
    logic       busy;
    logic [7:0] guess;
    logic       correct;
    logic       wrong;
    logic       timeout;
    logic [7:0] score;
    logic [7:0] streak;
    logic [7:0] guessSeg0;
    logic [7:0] guessSeg1;

    modport master (
        output answerSig, numSpecial, btnUp, btnDown, btnEnter,
        input  busy, guess, correct, wrong, timeout, score, streak,
        input  guessSeg0, guessSeg1
    );

    modport slave (
        input  answerSig, numSpecial, btnUp, btnDown, btnEnter,
        output busy, guess, correct, wrong, timeout, score, streak,
        output guessSeg0, guessSeg1
    );
endinterface

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
//  Module   : seg7_decode
//  Brief    : BCD digit to active-low 7-segment pattern with blanking.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_decode
    import sym_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [7:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (digit <= 4'd9)) begin
            seg = SEG_DIGITS[digit];
        end
    end
endmodule

`default_nettype wire

// File: rtl/answer_checker.sv
// ============================================================================
//  Module   : answer_checker
//  Brief    : Guess entry, grading, timeout and scoring after a game period.
//             Define ANSWER_STREAK_EN to enable the streak bonus scoring.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module answer_checker
    import sym_pkg::*;
#(
    parameter int MAX_GUESS      = 99,
    parameter int TIMEOUT_CYCLES = 1_000_000_000,
    parameter int RESULT_CYCLES  = 300_000_000
) (
    input  logic            Clk100M,
    input  logic            RstN,
    answer_checker_if.slave ans
);
    localparam int c_cnt_max = (TIMEOUT_CYCLES > RESULT_CYCLES) ? TIMEOUT_CYCLES : RESULT_CYCLES;
    localparam int c_cnt_w   = (c_cnt_max > 2) ? $clog2(c_cnt_max) : 1;
    localparam logic [c_cnt_w-1:0] c_tmo_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_res_last  = c_cnt_w'(RESULT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [7:0]         c_max_guess = 8'(MAX_GUESS);

    ans_state_t         r_state, w_state;
    logic [c_cnt_w-1:0] r_cnt, w_cnt;
    logic [7:0]         r_guess, w_guess, r_target, w_target, r_score, w_score;
    logic               r_correct, w_correct, r_wrong, w_wrong, r_timeout, w_timeout;
    logic               r_busy;
    logic [7:0]         r_seg0, r_seg1, w_seg0, w_seg1;
    logic               w_tmo_hit, w_res_done;
    logic [7:0]         w_score_inc;
    logic [8:0]         w_score_sum;
    logic [6:0]         w_disp;
    logic [3:0]         w_tens, w_ones;
    logic               w_blank_all, w_blank_tens;
`ifdef ANSWER_STREAK_EN
    logic [7:0]         r_streak, w_streak;
`endif

    function automatic logic [7:0] bcd_split(input logic [6:0] v);
        logic [6:0] rem;
        logic [3:0] tens;
        rem  = v;
        tens = '0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    assign w_tmo_hit  = (r_cnt == c_tmo_last);
    assign w_res_done = (r_cnt == c_res_last);

`ifdef ANSWER_STREAK_EN
    assign w_score_inc = (r_streak >= 8'd2) ? 8'd2 : 8'd1;
`else
    assign w_score_inc = 8'd1;
`endif
    assign w_score_sum = {1'b0, r_score} + {1'b0, w_score_inc};

    always_ff @(posedge Clk100M or negedge RstN) begin
        if (!RstN) r_state <= IDLE;
        else       r_state <= w_state;
    end

    always_comb begin
        w_state = r_state;
        case (r_state)
            IDLE:    if (ans.answerSig)              w_state = ENTRY;
            ENTRY:   if (ans.btnEnter || w_tmo_hit)  w_state = RESULT;
            RESULT:  if (w_res_done)                 w_state = IDLE;
            default:                                 w_state = IDLE;
        endcase
    end

    always_comb begin
        w_cnt     = r_cnt;
        w_guess   = r_guess;
        w_target  = r_target;
        w_score   = r_score;
        w_correct = r_correct;
        w_wrong   = r_wrong;
        w_timeout = r_timeout;
`ifdef ANSWER_STREAK_EN
        w_streak  = r_streak;
`endif
        case (r_state)
            IDLE: begin
                if (ans.answerSig) begin
                    w_target = ans.numSpecial;
                    w_guess  = '0;
                    w_cnt    = '0;
                end
            end
            ENTRY: begin
                // Enter grades the guess as it stood, ignoring same-cycle up/down
                if (ans.btnEnter) begin
                    w_cnt = '0;
                    if (r_guess == r_target) begin
                        w_correct = 1'b1;
                        w_score   = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
`ifdef ANSWER_STREAK_EN
                        w_streak  = (r_streak == 8'hFF) ? r_streak : r_streak + 8'd1;
`endif
                    end else begin
                        w_wrong   = 1'b1;
`ifdef ANSWER_STREAK_EN
                        w_streak  = '0;
`endif
                    end
                end else if (w_tmo_hit) begin
                    w_cnt     = '0;
                    w_timeout = 1'b1;
`ifdef ANSWER_STREAK_EN
                    w_streak  = '0;
`endif
                end else begin
                    w_cnt = r_cnt + c_cnt_one;
                    if (ans.btnUp && !ans.btnDown && (r_guess < c_max_guess)) begin
                        w_guess = r_guess + 8'd1;
                    end else if (ans.btnDown && !ans.btnUp && (r_guess != 8'd0)) begin
                        w_guess = r_guess - 8'd1;
                    end
                end
            end
            RESULT: begin
                if (w_res_done) begin
                    w_cnt     = '0;
                    w_correct = 1'b0;
                    w_wrong   = 1'b0;
                    w_timeout = 1'b0;
                end else begin
                    w_cnt = r_cnt + c_cnt_one;
                end
            end
            default: w_cnt = '0;
        endcase
    end

    // Display tracks next-cycle values so segments land together with guess/state
    always_comb begin
        w_disp = 7'(w_guess);
        if (w_state == RESULT) begin
            w_disp = (w_target > 8'd99) ? 7'd99 : w_target[6:0];
        end
    end

    assign {w_tens, w_ones} = bcd_split(w_disp);
    assign w_blank_all      = (w_state == IDLE);
    assign w_blank_tens     = w_blank_all || (w_tens == 4'd0);

    seg7_decode u_seg_ones (.digit(w_ones), .blank(w_blank_all),  .seg(w_seg0));
    seg7_decode u_seg_tens (.digit(w_tens), .blank(w_blank_tens), .seg(w_seg1));

    always_ff @(posedge Clk100M or negedge RstN) begin
        if (!RstN) begin
            r_cnt     <= '0;
            r_guess   <= '0;
            r_target  <= '0;
            r_score   <= '0;
            r_correct <= 1'b0;
            r_wrong   <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
            r_seg0    <= SEG_BLANK;
            r_seg1    <= SEG_BLANK;
        end else begin
            r_cnt     <= w_cnt;
            r_guess   <= w_guess;
            r_target  <= w_target;
            r_score   <= w_score;
            r_correct <= w_correct;
            r_wrong   <= w_wrong;
            r_timeout <= w_timeout;
            r_busy    <= (w_state != IDLE);
            r_seg0    <= w_seg0;
            r_seg1    <= w_seg1;
        end
    end

`ifdef ANSWER_STREAK_EN
    always_ff @(posedge Clk100M or negedge RstN) begin
        if (!RstN) r_streak <= '0;
        else       r_streak <= w_streak;
    end
    assign ans.streak = r_streak;
`else
    assign ans.streak = 8'd0;
`endif

    assign ans.busy      = r_busy;
    assign ans.guess     = r_guess;
    assign ans.correct   = r_correct;
    assign ans.wrong     = r_wrong;
    assign ans.timeout   = r_timeout;
    assign ans.score     = r_score;
    assign ans.guessSeg0 = r_seg0;
    assign ans.guessSeg1 = r_seg1;

endmodule

`default_nettype wire

// File: tb/tb_answer_checker.sv
// ============================================================================
//  Module   : tb_answer_checker
//  Brief    : Self-checking bench for answer_checker (vector table + scoreboard).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_answer_checker;
    localparam int TMO = 50;
    localparam int RES = 10;
`ifdef ANSWER_STREAK_EN
    localparam bit STREAK_EN = 1'b1;
`else
    localparam bit STREAK_EN = 1'b0;
`endif

    typedef struct packed {
        logic       busy;
        logic [7:0] guess;
        logic       correct;
        logic       wrong;
        logic       timeout;
        logic [7:0] score;
        logic [7:0] streak;
        logic [7:0] seg0;
        logic [7:0] seg1;
    } exp_t;

    typedef struct packed {
        logic [7:0] guess;
        logic       wrong;
        logic [7:0] seg0;
        logic [7:0] seg1;
    } exp2_t;

    typedef struct {
        bit         ans;
        logic [7:0] num;
        bit         up;
        bit         down;
        bit         enter;
        int         rep;
        exp_t       e;
        string      name;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    answer_checker_if bus();
    answer_checker_if bus2();

    answer_checker #(.MAX_GUESS(99), .TIMEOUT_CYCLES(TMO), .RESULT_CYCLES(RES)) dut (
        .Clk100M (clk),
        .RstN    (rst_n),
        .ans     (bus)
    );

    // Longer timeout so a full 0..99 sweep fits in one ENTRY dwell
    answer_checker #(.MAX_GUESS(99), .TIMEOUT_CYCLES(300), .RESULT_CYCLES(RES)) dut_sat (
        .Clk100M (clk),
        .RstN    (rst_n),
        .ans     (bus2)
    );

    exp_t  sb[$];
    exp2_t sb2[$];
    int    checks     = 0;
    int    errors     = 0;
    int    exp_score  = 0;
    int    exp_streak = 0;
    vec_t  tbl[7];
    int    req_score[3];

    function automatic logic [7:0] dseg(int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [15:0] segs(int disp, bit blank);
        logic [7:0] s0, s1;
        if (blank) return 16'hFFFF;
        s0 = dseg(disp % 10);
        s1 = (disp < 10) ? 8'hFF : dseg(disp / 10);
        return {s1, s0};
    endfunction

    function automatic exp_t ex(bit busy, int g, bit c, bit w, bit t, int disp, bit blank);
        exp_t e;
        logic [15:0] s;
        s         = segs(disp, blank);
        e.busy    = busy;
        e.guess   = 8'(g);
        e.correct = c;
        e.wrong   = w;
        e.timeout = t;
        e.score   = 8'(exp_score);
        e.streak  = STREAK_EN ? 8'(exp_streak) : 8'd0;
        e.seg0    = s[7:0];
        e.seg1    = s[15:8];
        return e;
    endfunction

    function automatic vec_t mkv(bit a, logic [7:0] n, bit u, bit d, bit en, int rep, exp_t e, string name);
        vec_t v;
        v.ans = a; v.num = n; v.up = u; v.down = d; v.enter = en;
        v.rep = rep; v.e = e; v.name = name;
        return v;
    endfunction

    task automatic grade_ok();
        int inc;
        inc        = (STREAK_EN && exp_streak >= 2) ? 2 : 1;
        exp_score  = (exp_score + inc > 255) ? 255 : exp_score + inc;
        exp_streak = (exp_streak >= 255) ? 255 : exp_streak + 1;
    endtask

    task automatic grade_bad();
        exp_streak = 0;
    endtask

    task automatic compare(string name);
        exp_t e, a;
        e = sb.pop_front();
        a.busy = bus.busy;       a.guess = bus.guess;     a.correct = bus.correct;
        a.wrong = bus.wrong;     a.timeout = bus.timeout; a.score = bus.score;
        a.streak = bus.streak;   a.seg0 = bus.guessSeg0;  a.seg1 = bus.guessSeg1;
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s @%0t: got busy=%0b guess=%0d cwt=%0b%0b%0b score=%0d streak=%0d seg1/0=%h/%h; expected busy=%0b guess=%0d cwt=%0b%0b%0b score=%0d streak=%0d seg1/0=%h/%h",
                     name, $time, a.busy, a.guess, a.correct, a.wrong, a.timeout, a.score, a.streak, a.seg1, a.seg0,
                     e.busy, e.guess, e.correct, e.wrong, e.timeout, e.score, e.streak, e.seg1, e.seg0);
        end
    endtask

    task automatic step(bit a, logic [7:0] num, bit up, bit down, bit enter, exp_t e, string name);
        @(negedge clk);
        bus.answerSig = a; bus.numSpecial = num;
        bus.btnUp = up; bus.btnDown = down; bus.btnEnter = enter;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.answerSig = 1'b0; bus.numSpecial = 8'd0;
        bus.btnUp = 1'b0; bus.btnDown = 1'b0; bus.btnEnter = 1'b0;
        compare(name);
    endtask

    task automatic idle(exp_t e, string name);
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, e, name);
    endtask

    task automatic wait_result(int g, bit c, bit w, bit t, int disp, string name);
        for (int i = 1; i < RES; i++) idle(ex(1'b1, g, c, w, t, disp, 1'b0), name);
        idle(ex(1'b0, g, 1'b0, 1'b0, 1'b0, 0, 1'b1), {name, "_end"});
    endtask

    task automatic step2(bit a, logic [7:0] num, bit up, bit down, bit enter, int g, bit w, string name);
        exp2_t e, act;
        logic [15:0] s;
        s = segs(g, 1'b0);
        e.guess = 8'(g); e.wrong = w; e.seg0 = s[7:0]; e.seg1 = s[15:8];
        @(negedge clk);
        bus2.answerSig = a; bus2.numSpecial = num;
        bus2.btnUp = up; bus2.btnDown = down; bus2.btnEnter = enter;
        sb2.push_back(e);
        @(posedge clk);
        #1;
        bus2.answerSig = 1'b0; bus2.numSpecial = 8'd0;
        bus2.btnUp = 1'b0; bus2.btnDown = 1'b0; bus2.btnEnter = 1'b0;
        act.guess = bus2.guess; act.wrong = bus2.wrong;
        act.seg0 = bus2.guessSeg0; act.seg1 = bus2.guessSeg1;
        e = sb2.pop_front();
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s @%0t: got guess=%0d wrong=%0b seg1/0=%h/%h; expected guess=%0d wrong=%0b seg1/0=%h/%h",
                     name, $time, act.guess, act.wrong, act.seg1, act.seg0, e.guess, e.wrong, e.seg1, e.seg0);
        end
    endtask

    task automatic check_val(string name, int act, int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.answerSig = 1'b0; bus.numSpecial = 8'd0;
        bus.btnUp = 1'b0; bus.btnDown = 1'b0; bus.btnEnter = 1'b0;
        bus2.answerSig = 1'b0; bus2.numSpecial = 8'd0;
        bus2.btnUp = 1'b0; bus2.btnDown = 1'b0; bus2.btnEnter = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        sb.push_back(ex(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1));
        compare("reset_state");
        rst_n = 1'b1;
        idle(ex(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1), "idle_after_reset");
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, ex(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1), "idle_up_ignored");
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, ex(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1), "idle_enter_ignored");

        // Round 1: target 3, three ups, enter
        tbl[0] = mkv(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1, ex(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0), "r1_start");
        tbl[1] = mkv(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1, ex(1'b1, 1, 1'b0, 1'b0, 1'b0, 1, 1'b0), "r1_up1");
        tbl[2] = mkv(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1, ex(1'b1, 2, 1'b0, 1'b0, 1'b0, 2, 1'b0), "r1_up2");
        tbl[3] = mkv(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1, ex(1'b1, 3, 1'b0, 1'b0, 1'b0, 3, 1'b0), "r1_up3");
        grade_ok();
        tbl[4] = mkv(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1, ex(1'b1, 3, 1'b1, 1'b0, 1'b0, 3, 1'b0), "r1_correct");
        tbl[5] = mkv(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, RES - 1, ex(1'b1, 3, 1'b1, 1'b0, 1'b0, 3, 1'b0), "r1_hold");
        tbl[6] = mkv(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1, ex(1'b0, 3, 1'b0, 1'b0, 1'b0, 0, 1'b1), "r1_done");
        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                step(tbl[i].ans, tbl[i].num, tbl[i].up, tbl[i].down, tbl[i].enter, tbl[i].e, tbl[i].name);
            end
        end
        check_val("r1_score", int'(bus.score), 1);

        // Saturation sweep on the long-timeout instance; target 200 is unmatchable
        step2(1'b1, 8'd200, 1'b0, 1'b0, 1'b0, 0, 1'b0, "sat_start");
        for (int i = 0; i < 2; i++) step2(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 0, 1'b0, "sat_down_floor");
        for (int i = 1; i <= 100; i++) step2(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, (i > 99) ? 99 : i, 1'b0, "sat_up");
        step2(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 99, 1'b0, "sat_up_down");
        step2(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 99, 1'b1, "sat_big_target_wrong");

        // Round 2: wrong answer, with floor and same-cycle up/down
        step(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, ex(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0), "r2_start");
        for (int i = 0; i < 2; i++) step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, ex(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0), "r2_down_floor");
        for (int i = 1; i <= 4; i++) step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, ex(1'b1, i, 1'b0, 1'b0, 1'b0, i, 1'b0), "r2_up");
        step(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, ex(1'b1, 4, 1'b0, 1'b0, 1'b0, 4, 1'b0), "r2_up_down");
        grade_bad();
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, ex(1'b1, 4, 1'b0, 1'b1, 1'b0, 5, 1'b0), "r2_wrong");
        wait_result(4, 1'b0, 1'b1, 1'b0, 5, "r2_result");

        // Round 3: no enter -> timeout after the 50th ENTRY cycle
        step(1'b1, 8'd7, 1'b0, 1'b0, 1'b0, ex(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0), "r3_start");
        for (int k = 1; k < TMO; k++) idle(ex(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0), "r3_dwell");
        grade_bad();
        idle(ex(1'b1, 0, 1'b0, 1'b0, 1'b1, 7, 1'b0), "r3_timeout");
        wait_result(0, 1'b0, 1'b0, 1'b1, 7, "r3_result");

        // Round 4: enter in the terminal-count cycle beats the timeout
        step(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, ex(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0), "r4_start");
        for (int k = 1; k < TMO; k++) idle(ex(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0), "r4_dwell");
        grade_ok();
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, ex(1'b1, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0), "r4_enter_at_tc");
        wait_result(0, 1'b1, 1'b0, 1'b0, 0, "r4_result");

        // Round 5: answerSig during ENTRY must not retarget or reset the guess
        step(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, ex(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0), "r5_start");
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, ex(1'b1, 1, 1'b0, 1'b0, 1'b0, 1, 1'b0), "r5_up1");
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, ex(1'b1, 2, 1'b0, 1'b0, 1'b0, 2, 1'b0), "r5_up2");
        step(1'b1, 8'd9, 1'b0, 1'b0, 1'b0, ex(1'b1, 2, 1'b0, 1'b0, 1'b0, 2, 1'b0), "r5_ans_ignored");
        grade_ok();
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, ex(1'b1, 2, 1'b1, 1'b0, 1'b0, 2, 1'b0), "r5_target_kept");
        wait_result(2, 1'b1, 1'b0, 1'b0, 2, "r5_result");

        // Asynchronous reset mid-ENTRY
        step(1'b1, 8'd4, 1'b0, 1'b0, 1'b0, ex(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0), "r6_start");
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, ex(1'b1, 1, 1'b0, 1'b0, 1'b0, 1, 1'b0), "r6_up");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_score  = 0;
        exp_streak = 0;
        sb.push_back(ex(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1));
        compare("async_reset_mid_entry");
        @(negedge clk);
        rst_n = 1'b1;

        // Three consecutive correct rounds from a cleared score
        req_score[0] = 1;
        req_score[1] = 2;
        req_score[2] = STREAK_EN ? 4 : 3;
        for (int r = 0; r < 3; r++) begin
            step(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, ex(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0), "r7_start");
            step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, ex(1'b1, 1, 1'b0, 1'b0, 1'b0, 1, 1'b0), "r7_up");
            grade_ok();
            step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, ex(1'b1, 1, 1'b1, 1'b0, 1'b0, 1, 1'b0), "r7_correct");
            check_val("r7_score_progress", int'(bus.score), req_score[r]);
            wait_result(1, 1'b1, 1'b0, 1'b0, 1, "r7_result");
        end
        check_val("r7_final_streak", int'(bus.streak), STREAK_EN ? 3 : 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/answer_checker.md
# answer_checker

Post-period answer stage that sits directly downstream of the game-period block. It starts on that block's one-cycle `answerSig` pulse and latches `numSpecial` as the target. It then lets the player dial in a guess with up/down/enter pulses, grades the guess or times out, and keeps a running score. It also drives two 7-segment digits that show the guess, and then the correct answer.

## Interface
- `MAX_GUESS`, 99: highest enterable guess (two decimal digits).
- `TIMEOUT_CYCLES`, 1_000_000_000: maximum ENTRY dwell in clock cycles (10 s at 100 MHz).
- `RESULT_CYCLES`, 300_000_000: RESULT display dwell in cycles (3 s).
- `Clk100M`  in  1  system clock; all logic is on its rising edge.
- `RstN`  in  1  reset, asynchronous, active-low.
- `answerSig`  in  1  one-cycle pulse; the game period has ended.
- `numSpecial`  in  8  count of special symbols; valid in the `answerSig` cycle.
- `btnUp`, `btnDown`, `btnEnter`  in  1 each  debounced one-cycle pulses.
- `busy`  out  1  high in ENTRY and RESULT.
- `guess`  out  8  current guess.
- `correct`, `wrong`, `timeout`  out  1 each  result flags, held for the whole of RESULT.
- `score`  out  8  cumulative score.
- `streak`  out  8  consecutive correct answers.
- `guessSeg0`, `guessSeg1`  out  8 each  active-low segments for ones and tens; 8'hFF means blank.

## Operation
- FSM states are IDLE, ENTRY and RESULT.
- IDLE:
  - On `answerSig`, latch `target` = `numSpecial`, set `guess` = 0, clear the timeout counter and go to ENTRY.
  - Buttons are ignored.
- ENTRY:
  - `btnUp` increments `guess`, saturating at MAX_GUESS.
  - `btnDown` decrements `guess`, saturating at 0.
  - `btnUp` and `btnDown` in the same cycle leave `guess` unchanged.
  - `btnEnter` grades the pre-update `guess`, and takes priority over up/down in the same cycle.
    - If `guess` == `target`: set `correct`, add 1 to `score` (saturating at 255) and add 1 to `streak` (saturating at 255).
    - Otherwise: set `wrong` and clear `streak`.
  - When the counter reaches TIMEOUT_CYCLES−1 with no enter: set `timeout` and clear `streak`.
  - If enter and timeout land in the same cycle, enter wins.
  - Grading or timeout moves the FSM to RESULT and clears the dwell counter.
- RESULT:
  - Flags hold for RESULT_CYCLES cycles, then all flags clear and the FSM returns to IDLE.
- `answerSig` is ignored in ENTRY and RESULT. No queueing.
- A `target` above 99 can never be matched; the round ends with `wrong` or `timeout`.
- Segment display:
  - IDLE: both digits blank.
  - ENTRY: the BCD digits of `guess`; the tens digit is blank when `guess` < 10.
  - RESULT: the BCD digits of min(`target`, 99).

## Timing
- Every output is a register.
- An input pulse in cycle N is reflected in the outputs in cycle N+1.
- `busy` rises in the cycle after `answerSig`.
- Result flags rise in the cycle after the enter pulse or the terminal timeout count.
- Flags and `busy` fall exactly RESULT_CYCLES cycles after they rise.
- Counter width is $clog2(max(TIMEOUT_CYCLES, RESULT_CYCLES)). One counter is shared between ENTRY and RESULT.
- Reset values:
  - state IDLE;
  - `guess`, `target`, `score`, `streak` = 0;
  - all flags and `busy` = 0;
  - both segment outputs = 8'hFF.
- Reset asserted mid-round returns the block to IDLE immediately and clears `score`.

## Configuration
- `ANSWER_STREAK_EN` defined: a correct answer given while `streak` ≥ 2 (value before the increment) adds 2 to `score`, saturating at 255.
- `ANSWER_STREAK_EN` undefined: every correct answer adds 1, and the `streak` port is tied to 0. The port list is the same in both builds.

## Structure
- The shared package `sym_pkg` holds:
  - the state enum `ans_state_t` (IDLE, ENTRY, RESULT);
  - `SEG_BLANK` = 8'hFF;
  - the 10-entry active-low digit segment constant table.
- One sub-module, `seg7_decode`: a 4-bit BCD digit plus a blank input in, 8-bit active-low segments out. It is instantiated twice.
- Binary-to-BCD for values 0–99 is done in `answer_checker` by comparison and subtraction.

## Test plan
Bench parameters: TIMEOUT_CYCLES=50, RESULT_CYCLES=10.
- Pulse `answerSig` with `numSpecial`=3, then 3× `btnUp` and `btnEnter`.
  - `correct`=1 for 10 cycles, `score`=1, `streak`=1.
  - During RESULT: `guessSeg0` shows 3 and `guessSeg1` is blank.
  - Afterwards `busy`=0.
- In ENTRY, 2× `btnDown` from 0 → `guess`=0. With MAX_GUESS=99, 100× `btnUp` → `guess`=99. Then `btnUp`+`btnDown` in the same cycle → still 99.
- `numSpecial`=5, guess 4, enter → `wrong`=1, `score` unchanged, `streak`=0.
- No enter for 50 cycles → `timeout`=1 in the cycle after the 50th ENTRY cycle. `btnEnter` in the terminal-count cycle → graded instead, `timeout`=0.
- `answerSig` during ENTRY → target unchanged. Deassert `RstN` mid-ENTRY → all outputs return to reset values on the same edge.
- With `ANSWER_STREAK_EN`: three consecutive correct rounds → `score` goes 1, 2, 4 and `streak`=3. Without the macro: `score`=3, `streak`=0.
